ps2_receiver: RTL and testbench

Front-end of the keyboard path: synchronises the raw PS/2 clock/data lines, deserialises 11-bit device-to-host frames, checks parity and framing, and strips the E0/F0 prefixes. It drives the held 8-bit make code straight into the scan-code decoder's `ps2InCode` input. `ps2Code` holds the currently pressed key and returns to 8'h00 on its release. A one-cycle `codeValid` strobe marks every accepted update.

---
 rtl/ps2_receiver.sv | 184 ++++++++++++++++++
 tb/tb_ps2_receiver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: line sync, clock glitch filter, 11-bit frame
// deserialiser with parity/stop/timeout checks, and E0/F0 prefix stripping.
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] ps2Code,
    output logic       codeValid,
    output logic       frameErr
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // ------------------------------------------------------------------
    // Two-flop synchronisers, idle-high
    // ------------------------------------------------------------------
    logic r_clk_s1, r_clk_s2;
    logic r_dat_s1, r_dat_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2Clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2Data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter: the level flips on the FILTER_LEN-th consecutive
    // differing sample; any agreeing sample restarts the run.
    // ------------------------------------------------------------------
    logic          r_filt;
    logic [FW-1:0] r_fcnt;
    logic          w_flip;
    logic          w_filt_fall;
    logic          r_fall;

    assign w_flip      = (r_clk_s2 != r_filt) && (r_fcnt == FW'(FILTER_LEN - 1));
    assign w_filt_fall = w_flip && r_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
            r_fall <= 1'b0;
        end else begin
            r_fall <= w_filt_fall;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (w_flip) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM state
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shreg;
    logic          r_parOk;
    logic [TW-1:0] r_to;
    logic          r_breakPend;
    logic          r_extPend;
    logic [7:0]    r_code;
    logic          r_valid;
    logic          r_err;

    logic w_to_hit;
    logic w_stop_evt;
    logic w_byte_ok;

    // A coincident fall keeps the frame alive even at terminal count.
    assign w_to_hit   = (r_state != S_IDLE) && (r_to == TW'(TIMEOUT_CYCLES)) && !r_fall;
    assign w_stop_evt = r_fall && (r_state == S_STOP);
    assign w_byte_ok  = w_stop_evt && r_dat_s2 && r_parOk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to <= '0;
        end else if (r_fall || r_state == S_IDLE) begin
            r_to <= '0;
        end else begin
            r_to <= r_to + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitCnt <= 3'd0;
            r_shreg  <= 8'h00;
            r_parOk  <= 1'b0;
        end else if (w_to_hit) begin
            r_state <= S_IDLE;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        r_state  <= S_DATA;
                        r_bitCnt <= 3'd0;
                    end
                end
                S_DATA: begin
                    r_shreg  <= {r_dat_s2, r_shreg[7:1]};
                    r_bitCnt <= r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) r_state <= S_PARITY;
                end
                S_PARITY: begin
                    r_parOk <= ^{r_dat_s2, r_shreg};
                    r_state <= S_STOP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prefix handling and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_breakPend <= 1'b0;
            r_extPend   <= 1'b0;
            r_code      <= 8'h00;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_to_hit || (w_stop_evt && !w_byte_ok)) begin
                r_err       <= 1'b1;
                r_breakPend <= 1'b0;
                r_extPend   <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_shreg == BREAK_CODE) begin
                    r_breakPend <= 1'b1;
                end else if (r_shreg == EXT_CODE) begin
                    r_extPend <= 1'b1;
                end else if (r_extPend) begin
                    r_extPend   <= 1'b0;
                    r_breakPend <= 1'b0;
                end else if (r_breakPend) begin
                    r_breakPend <= 1'b0;
                    if (r_shreg == r_code) begin
                        r_code  <= 8'h00;
                        r_valid <= 1'b1;
                    end
                end else begin
                    r_code  <= r_shreg;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign ps2Code   = r_code;
    assign codeValid = r_valid;
    assign frameErr  = r_err;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of whole frames plus hand-built
// timeout, glitch and mid-frame reset sequences.
module tb_ps2_receiver;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 50;
    localparam int HALF       = 22;
    localparam int GAP        = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] ps2Code;
    logic       codeValid;
    logic       frameErr;

    int tests = 0;
    int fails = 0;
    int vcnt = 0;
    int ecnt = 0;
    int overlap = 0;

    ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
        .ps2Code(ps2Code), .codeValid(codeValid), .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (codeValid) vcnt++;
        if (frameErr) ecnt++;
        if (codeValid && frameErr) overlap++;
    end

    typedef struct {
        logic [7:0] b;
        logic       bad_par;
        logic       stop;
        logic [7:0] exp_code;
        int         exp_v;
        int         exp_e;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // nbits < 11 stops clocking early; abort_bit asserts reset at that bit;
    // glitch_bit drops ps2Clk for FILTER_LEN-1 cycles late in its high phase.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input int nbits, input int glitch_bit, input int abort_bit);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_bit) begin
                reset = 1'b1;
                cyc(3);
                reset = 1'b0;
                ps2Data = 1'b1;
                ps2Clk = 1'b1;
                cyc(GAP);
                return;
            end
            ps2Data = bits[i];
            if (i == glitch_bit) begin
                cyc(12);
                ps2Clk = 1'b0;
                cyc(FILTER_LEN - 1);
                ps2Clk = 1'b1;
                cyc(HALF - 12 - (FILTER_LEN - 1));
            end else begin
                cyc(HALF);
            end
            ps2Clk = 1'b0;
            cyc(HALF);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
        cyc(GAP);
    endtask

    initial begin
        int v0, e0;
        vecs[0]  = '{8'h16, 1'b0, 1'b1, 8'h16, 1, 0};
        vecs[1]  = '{8'h2D, 1'b0, 1'b1, 8'h2D, 1, 0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b1, 8'h2D, 0, 0};
        vecs[3]  = '{8'h2D, 1'b0, 1'b1, 8'h00, 1, 0};
        vecs[4]  = '{8'h34, 1'b0, 1'b1, 8'h34, 1, 0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b1, 8'h34, 0, 0};
        vecs[6]  = '{8'h32, 1'b0, 1'b1, 8'h34, 0, 0};
        vecs[7]  = '{8'hE0, 1'b0, 1'b1, 8'h34, 0, 0};
        vecs[8]  = '{8'h75, 1'b0, 1'b1, 8'h34, 0, 0};
        vecs[9]  = '{8'h26, 1'b1, 1'b1, 8'h34, 0, 1};
        vecs[10] = '{8'h26, 1'b0, 1'b0, 8'h34, 0, 1};
        vecs[11] = '{8'h34, 1'b0, 1'b1, 8'h34, 1, 0};

        reset = 1'b1;
        ps2Clk = 1'b1;
        ps2Data = 1'b1;
        cyc(5);
        reset = 1'b0;
        cyc(1);
        chk("reset_code", ps2Code, 8'h00);
        chk("reset_valid", codeValid, 0);
        chk("reset_err", frameErr, 0);
        cyc(GAP);

        for (int i = 0; i < 12; i++) begin
            v0 = vcnt;
            e0 = ecnt;
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop, 11, -1, -1);
            chk($sformatf("vec%0d_code", i), ps2Code, vecs[i].exp_code);
            chk($sformatf("vec%0d_valid", i), vcnt - v0, vecs[i].exp_v);
            chk($sformatf("vec%0d_err", i), ecnt - e0, vecs[i].exp_e);
        end

        // Timeout: start + 4 data bits, then the clock stays high.
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h1E, 1'b0, 1'b1, 5, -1, -1);
        cyc(60);
        chk("timeout_err", ecnt - e0, 1);
        chk("timeout_valid", vcnt - v0, 0);
        chk("timeout_code", ps2Code, 8'h34);
        v0 = vcnt;
        send_frame(8'h1E, 1'b0, 1'b1, 11, -1, -1);
        chk("post_to_code", ps2Code, 8'h1E);
        chk("post_to_valid", vcnt - v0, 1);

        // Sub-threshold glitch on ps2Clk during data bit 2.
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h45, 1'b0, 1'b1, 11, 3, -1);
        chk("glitch_code", ps2Code, 8'h45);
        chk("glitch_valid", vcnt - v0, 1);
        chk("glitch_err", ecnt - e0, 0);

        // Reset at bit 5 of a frame, then a clean frame.
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 5);
        chk("rst_mid_code", ps2Code, 8'h00);
        chk("rst_mid_valid", vcnt - v0, 0);
        chk("rst_mid_err", ecnt - e0, 0);
        v0 = vcnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, -1);
        chk("post_rst_code", ps2Code, 8'h1C);
        chk("post_rst_valid", vcnt - v0, 1);

        chk("strobe_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
